// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: memory-mapped 8N1 UART receiver with a byte FIFO.
// Serial input goes through a 2-flop synchroniser, a mid-bit sampling FSM
// and then a FIFO. The FIFO is popped through a combinational read port.
// Optional feature: define UART_PARITY_EN for even parity (8E1 framing).
// Without it the block is 8N1 only and PERR always reads 0.

module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] RXD_ADDR   = 32'h4000_0018,
    parameter logic [31:0] CON_ADDR   = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_rxd,
    output logic        irqout
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             sync1;
    logic             sync2;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    logic             tick_c;
    logic             push_c;
    logic             ferr_set_c;
    logic             perr_set_c;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             empty;
    logic             full;
    logic             pop_c;
    logic             push_ok_c;
    logic             ovr_set_c;
    logic             con_wr_c;

    logic             irq_en;
    logic             ovr;
    logic             ferr;
    logic             perr;

    logic             unused_wdata;
    assign unused_wdata = ^{wdata[31:5], wdata[0]};

    // Two-flop synchroniser; loads idle-high so reset release never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= UART_rxd;
            sync2 <= sync1;
        end
    end

    assign rxd_s = sync2;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef UART_PARITY_EN
    logic par_bad;
`endif

    // Next-state and per-cycle strobes: sample points, push, error sets
    always_comb begin
        state_nxt  = state;
        tick_c     = 1'b0;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        perr_set_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    tick_c    = 1'b1;
                    state_nxt = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_W'(DIV - 1)) begin
                    tick_c = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt == CNT_W'(DIV - 1)) begin
                    tick_c     = 1'b1;
                    perr_set_c = (rxd_s != ^shift);
                    state_nxt  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == CNT_W'(DIV - 1)) begin
                    tick_c = 1'b1;
                    if (rxd_s) begin
`ifdef UART_PARITY_EN
                        push_c = ~par_bad;
`else
                        push_c = 1'b1;
`endif
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_nxt  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxd_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Baud counter, bit counter and LSB-first shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (state == S_IDLE || state == S_BREAK || tick_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == S_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (state == S_DATA && tick_c) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == S_DATA && tick_c) begin
                shift <= {rxd_s, shift[7:1]};
            end
        end
    end

`ifdef UART_PARITY_EN
    // Parity-failure marker for the frame in flight, cleared at each new frame
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bad <= 1'b0;
        end else if (state == S_IDLE) begin
            par_bad <= 1'b0;
        end else if (perr_set_c) begin
            par_bad <= 1'b1;
        end
    end
`endif

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_c     = rd && (addr == RXD_ADDR) && !empty;
    assign push_ok_c = push_c && (!full || pop_c);
    assign ovr_set_c = push_c && full && !pop_c;
    assign con_wr_c  = wr && (addr == CON_ADDR);

    // FIFO storage and pointers; pop takes effect before push in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (pop_c) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (push_ok_c) begin
                mem[wptr[AW-1:0]] <= shift;
                wptr              <= wptr + PTR_W'(1);
            end
        end
    end

    // Status flags: a same-cycle set beats write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            ovr    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (con_wr_c) begin
                irq_en <= wdata[2];
            end
            ovr  <= ovr_set_c  | (ovr  & ~(con_wr_c & wdata[1]));
            ferr <= ferr_set_c | (ferr & ~(con_wr_c & wdata[3]));
        end
    end

`ifdef UART_PARITY_EN
    // Parity error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            perr <= 1'b0;
        end else begin
            perr <= perr_set_c | (perr & ~(con_wr_c & wdata[4]));
        end
    end
`else
    logic unused_par;
    assign unused_par = ^{perr_set_c, wdata[4]};
    assign perr       = 1'b0;
`endif

    // Interrupt request, one cycle behind the status it reflects
    always_ff @(posedge clk) begin
        if (reset) begin
            irqout <= 1'b0;
        end else begin
            irqout <= irq_en & (~empty | ovr | ferr | perr);
        end
    end

    // Combinational read port for the MEM stage
    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            if (addr == RXD_ADDR) begin
                rdata = {24'h0, empty ? 8'h00 : mem[rptr[AW-1:0]]};
            end else if (addr == CON_ADDR) begin
                rdata = {27'h0, perr, ferr, irq_en, ovr, ~empty};
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a shortened bit time (DIV = 16).
// Build with +define+UART_PARITY_EN to exercise the even-parity path.

module tb_uart_rx_fifo;

    localparam int unsigned DIV      = 16;
    localparam logic [31:0] RXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] CON_ADDR = 32'h4000_0020;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rxd;
    logic        irqout;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [31:0] rv;

`ifdef UART_PARITY_EN
    logic par_bit;
`endif

    uart_rx_fifo #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (8),
        .RXD_ADDR   (RXD_ADDR),
        .CON_ADDR   (CON_ADDR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .UART_rxd (rxd),
        .irqout   (irqout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd   = 1'b1;
        addr = a;
        #1 d = rdata;
        @(posedge clk);
        #1;
        rd   = 1'b0;
        addr = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rxd = par_bit;
        repeat (DIV) @(negedge clk);
`endif
        rxd = stop_bit;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        rxd      = 1'b1;
`ifdef UART_PARITY_EN
        par_bit  = 1'b0;
`endif
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        bus_read(CON_ADDR, rv);
        check("reset_con", rv, 32'h0);
        check("reset_irq", {31'h0, irqout}, 32'h0);
        bus_read(RXD_ADDR, rv);
        check("reset_rxd_empty", rv, 32'h0);

        // Single byte 0xA5
`ifdef UART_PARITY_EN
        par_bit = ^8'hA5;
`endif
        send_frame(8'hA5, 1'b1);
        bus_read(CON_ADDR, rv);
        check("a5_con", rv, 32'h1);
        #1 check("rd_low_rdata", rdata, 32'h0);
        bus_write(RXD_ADDR, 32'hFF);
        bus_read(RXD_ADDR, rv);
        check("a5_data", rv, 32'hA5);
        bus_read(CON_ADDR, rv);
        check("a5_con_after", rv, 32'h0);

        // Interrupt on arrival, drops one cycle after pop
        bus_write(CON_ADDR, 32'h4);
        bus_read(CON_ADDR, rv);
        check("irqen_con", rv, 32'h4);
        check("irq_idle", {31'h0, irqout}, 32'h0);
`ifdef UART_PARITY_EN
        par_bit = ^8'h3C;
`endif
        send_frame(8'h3C, 1'b1);
        check("irq_set", {31'h0, irqout}, 32'h1);
        bus_read(RXD_ADDR, rv);
        check("3c_data", rv, 32'h3C);
        check("irq_lag", {31'h0, irqout}, 32'h1);
        @(posedge clk);
        #1 check("irq_clear", {31'h0, irqout}, 32'h0);

        // Overrun: nine bytes into an eight-entry FIFO
        bus_write(CON_ADDR, 32'h0);
        for (int i = 1; i <= 9; i++) begin
`ifdef UART_PARITY_EN
            par_bit = ^8'(i);
`endif
            send_frame(8'(i), 1'b1);
        end
        bus_read(CON_ADDR, rv);
        check("ovr_con", rv, 32'h3);
        check("ovr_irq_off", {31'h0, irqout}, 32'h0);
        bus_write(CON_ADDR, 32'h2);
        bus_read(CON_ADDR, rv);
        check("ovr_cleared", rv, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            bus_read(RXD_ADDR, rv);
            check($sformatf("fifo_%0d", i), rv, 32'(i));
        end
        bus_read(CON_ADDR, rv);
        check("fifo_drained", rv, 32'h0);

        // Framing error with stop bit low
`ifdef UART_PARITY_EN
        par_bit = ^8'h55;
`endif
        send_frame(8'h55, 1'b0);
        bus_read(CON_ADDR, rv);
        check("ferr_con", rv, 32'h8);
        bus_read(RXD_ADDR, rv);
        check("ferr_rxd", rv, 32'h0);
        bus_write(CON_ADDR, 32'h8);
        bus_read(CON_ADDR, rv);
        check("ferr_cleared", rv, 32'h0);

        // Two-clock low glitch on the idle line
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        bus_read(CON_ADDR, rv);
        check("glitch_con", rv, 32'h0);

        // Reset during data bit 4 clears FIFO and aborts the frame
`ifdef UART_PARITY_EN
        par_bit = ^8'h11;
`endif
        send_frame(8'h11, 1'b1);
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            repeat (DIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        bus_read(CON_ADDR, rv);
        check("midreset_con", rv, 32'h0);
        bus_read(RXD_ADDR, rv);
        check("midreset_rxd", rv, 32'h0);
`ifdef UART_PARITY_EN
        par_bit = ^8'h7E;
`endif
        send_frame(8'h7E, 1'b1);
        bus_read(RXD_ADDR, rv);
        check("after_reset_7e", rv, 32'h7E);
        bus_read(CON_ADDR, rv);
        check("after_reset_con", rv, 32'h0);

`ifdef UART_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        par_bit = 1'b1;
        send_frame(8'h07, 1'b1);
        bus_read(CON_ADDR, rv);
        check("par_ok_con", rv, 32'h1);
        bus_read(RXD_ADDR, rv);
        check("par_ok_data", rv, 32'h07);
        par_bit = 1'b0;
        send_frame(8'h07, 1'b1);
        bus_read(CON_ADDR, rv);
        check("par_bad_con", rv, 32'h10);
        bus_write(CON_ADDR, 32'h10);
        bus_read(CON_ADDR, rv);
        check("par_cleared", rv, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
